// File: rtl/button_if.sv
// Pin-side interface for button_debouncer: raw level in, filtered level and edge strobes out.
// press_count exists only when BUTTON_PRESS_COUNT_EN is defined.
interface button_if;
  logic noisy;
  logic debounced;
  logic p_edge;
  logic n_edge;
  logic _edge;
`ifdef BUTTON_PRESS_COUNT_EN
  logic [15:0] press_count;

  modport master (input noisy, output debounced, p_edge, n_edge, _edge, press_count);
  modport slave  (output noisy, input debounced, p_edge, n_edge, _edge, press_count);
`else
  modport master (input noisy, output debounced, p_edge, n_edge, _edge);
  modport slave  (output noisy, input debounced, p_edge, n_edge, _edge);
`endif
endinterface

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus a four-state qualify-and-hold FSM for a bouncing button.
// Optional press counter is enabled with `define BUTTON_PRESS_COUNT_EN.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic     clk,
  input  logic     reset_n,
  button_if.master bus
);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s;
  state_t           state;
  logic [CNT_W-1:0] timer;
  logic             debounced_q;
  logic             prev;
  logic             p_edge_w, n_edge_w;

  // NOTE: non-blocking assignments make s1 and s two distinct flop stages;
  // blocking here would collapse the synchroniser into a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= bus.noisy;
      s  <= s1;
    end
  end

  // debounced is updated together with the state so it is a pure flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ZERO;
      timer       <= '0;
      debounced_q <= 1'b0;
    end else begin
      case (state)
        ZERO: begin
          if (s) begin
            state <= WAIT1;
            timer <= LOAD;
          end
        end
        WAIT1: begin
          if (!s) begin
            state <= ZERO;
          end else if (timer == '0) begin
            state       <= ONE;
            debounced_q <= 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ONE: begin
          if (!s) begin
            state <= WAIT0;
            timer <= LOAD;
          end
        end
        WAIT0: begin
          if (s) begin
            state <= ONE;
          end else if (timer == '0) begin
            state       <= ZERO;
            debounced_q <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state       <= ZERO;
          debounced_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= 1'b0;
    else          prev <= debounced_q;
  end

  assign p_edge_w      = debounced_q & ~prev;
  assign n_edge_w      = ~debounced_q & prev;
  assign bus.debounced = debounced_q;
  assign bus.p_edge    = p_edge_w;
  assign bus.n_edge    = n_edge_w;
  assign bus._edge     = p_edge_w | n_edge_w;

`ifdef BUTTON_PRESS_COUNT_EN
  logic [15:0] press_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      press_cnt <= '0;
    else if (p_edge_w) press_cnt <= press_cnt + 16'd1;
  end

  assign bus.press_count = press_cnt;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboarded bench for button_debouncer with DEBOUNCE_CYCLES=8: stimulus pushes the
// expected edge (cycle and level), the monitor pops it whenever the DUT strobes _edge.
module tb_button_debouncer;

  localparam int DC  = 8;
  localparam int LAT = DC + 3;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  button_if bus ();

  button_debouncer #(.DEBOUNCE_CYCLES(DC), .CNT_W(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int   cyc;
    logic lvl;
  } exp_t;

  typedef struct {
    logic lvl;
    int   hold;
    logic chg;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  exp_t e_mon, e_drop;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  logic exp_level = 1'b0;
  bit   done      = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every strobe must match the oldest pending expectation; otherwise level holds.
  initial forever begin
    @(negedge clk);
    if (!done) begin
      if (!reset_n) begin
        exp_level = 1'b0;
        check("reset_level", bus.debounced, 0);
        check("reset_edge", bus._edge, 0);
      end else if (bus._edge) begin
        check("edge_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e_mon = sb.pop_front();
          check("edge_cycle", cyc, e_mon.cyc);
          check("edge_level", bus.debounced, e_mon.lvl);
          check("p_edge", bus.p_edge, e_mon.lvl);
          check("n_edge", bus.n_edge, !e_mon.lvl);
          exp_level = e_mon.lvl;
        end
      end else begin
        check("level", bus.debounced, exp_level);
        check("quiet_p", bus.p_edge, 0);
        check("quiet_n", bus.n_edge, 0);
      end
    end
  end

  task automatic add(input logic l, input int h, input logic c);
    vec_t v;
    v.lvl  = l;
    v.hold = h;
    v.chg  = c;
    vecs.push_back(v);
  endtask

  // Called on a negedge; the following posedge is the first to sample the new level.
  task automatic apply(input logic l, input int h, input logic c);
    exp_t e;
    bus.noisy = l;
    if (c) begin
      e.cyc = cyc + LAT;
      e.lvl = l;
      sb.push_back(e);
    end
    repeat (h) @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.noisy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_debounced", bus.debounced, 0);
    check("rst_p_edge", bus.p_edge, 0);
    check("rst_n_edge", bus.n_edge, 0);
    check("rst_any_edge", bus._edge, 0);
`ifdef BUTTON_PRESS_COUNT_EN
    check("rst_press_count", bus.press_count, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    add(1, 14, 1);                                   // clean press
    add(0, 14, 1);                                   // clean release
    for (int i = 0; i < 5; i++) begin                // toggle every 3 clocks, 30 clocks
      add(1, 3, 0);
      add(0, 3, 0);
    end
    add(1, 14, 1);                                   // settle high after the bounce train
    for (int i = 0; i < 2; i++) begin                // short low glitches while held
      add(0, 3, 0);
      add(1, 3, 0);
    end
    add(0, 14, 1);
    add(1, 7, 0);                                    // 7-clock pulse: filtered
    add(0, 14, 0);
    add(1, 9, 1);                                    // 9-clock pulse: shortest that qualifies
    add(0, 14, 1);
    for (int i = 0; i < 5; i++) begin                // five short bounces, then a long hold
      add(1, 5, 0);
      add(0, 5, 0);
    end
    add(1, 14, 1);
    add(0, 14, 1);

    foreach (vecs[i]) apply(vecs[i].lvl, vecs[i].hold, vecs[i].chg);

`ifdef BUTTON_PRESS_COUNT_EN
    check("press_count_4", bus.press_count, 4);
`endif

    // Reset in WAIT1 with timer=4 (6 edges after the press is first sampled).
    bus.noisy = 1'b1;
    e_drop.cyc = cyc + LAT;
    e_drop.lvl = 1'b1;
    sb.push_back(e_drop);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    e_drop  = sb.pop_back();
    #1;
    check("midrst_debounced", bus.debounced, 0);
    check("midrst_edge", bus._edge, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    apply(1, LAT + 3, 1);

`ifdef BUTTON_PRESS_COUNT_EN
    check("press_count_after_reset", bus.press_count, 1);
`endif

    @(negedge clk);
    done = 1'b1;
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Debounces a mechanical push-button input (`noisy`) in the `clk` domain.
- Outputs a clean level (`debounced`) plus single-cycle edge strobes: rising, falling and either.
- Sits between a raw board pin and control logic.
- Input is asynchronous; the block synchronises it internally.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000, consecutive stable clocks required before `debounced` changes (20 ms at 100 MHz); legal range 1..2^24.
- CNT_W, 24, timer width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- noisy  in  1  raw asynchronous button level, may bounce.
- debounced  out  1  filtered level, registered.
- p_edge  out  1  one-cycle pulse on `debounced` 0->1.
- n_edge  out  1  one-cycle pulse on `debounced` 1->0.
- _edge  out  1  p_edge OR n_edge.

Behaviour:
- Reset (reset_n=0, async):
  - sync flops = 0, FSM = ZERO, timer = 0.
  - debounced = 0, p_edge = n_edge = _edge = 0.
  - Reset mid-count abandons the count immediately.
- Synchroniser:
  - Two flops, `noisy` -> s1 -> s.
  - The FSM uses only `s`.
- FSM states: ZERO, WAIT1, ONE, WAIT0.
  - ZERO: if s=1, go to WAIT1 and load timer = DEBOUNCE_CYCLES-1.
  - WAIT1:
    - if s=0, return to ZERO (count discarded);
    - else if timer=0, go to ONE;
    - else decrement timer.
  - ONE: if s=0, go to WAIT0 and load timer = DEBOUNCE_CYCLES-1.
  - WAIT0: mirror of WAIT1 with levels swapped; exits to ONE on s=1, to ZERO on timer=0.
- `debounced` is registered: 1 in ONE and WAIT0, 0 in ZERO and WAIT1.
- Latency: a level change on `noisy` held stable changes `debounced` at rising edge DEBOUNCE_CYCLES+3, counting as edge 1 the first edge that samples the new level.
- Filtering:
  - Any reversal of `s` before the timer expires restarts qualification from zero.
  - Pulses or bounce trains shorter than DEBOUNCE_CYCLES never reach `debounced`.
- Edges:
  - A `prev` register holds `debounced` delayed by one clock.
  - p_edge = debounced & ~prev; n_edge = ~debounced & prev; _edge = p_edge | n_edge.
  - Each is high for exactly the first cycle of the new level; p_edge and n_edge are never simultaneously 1.
- Reset release while noisy=1: behaves as a fresh press; debounced rises after DEBOUNCE_CYCLES+3 edges and p_edge fires once.
- Timer never wraps; it is only loaded or decremented while nonzero.
- No other outputs change.

Optional Feature:
- Macro: BUTTON_PRESS_COUNT_EN.
- Defined:
  - Adds output `press_count`, 16 bits.
  - Increments on every p_edge cycle and wraps 0xFFFF -> 0x0000.
  - Reset value 0 (async, reset_n).
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=8: reset, then noisy=1 held -> debounced 0 for 10 edges, 1 at edge 11; p_edge and _edge high exactly that one cycle; n_edge stays 0.
- DEBOUNCE_CYCLES=8, debounced=1: noisy=0 held -> debounced falls at edge 11; n_edge and _edge pulse once.
- DEBOUNCE_CYCLES=8: toggle noisy every 3 clocks for 30 clocks -> debounced, p_edge and n_edge stay 0; after noisy settles at 1, debounced rises 11 edges later.
- Default parameter, 100 MHz:
  - noisy=1 for 50 ms, then 0 for 50 ms -> debounced high from about 20 ms to about 70 ms.
  - Five 1.25 ms bounces, then 25 ms hold -> exactly one clean transition.
- Assert reset_n=0 mid-WAIT1 (timer=4) -> all outputs 0 immediately, no edge pulse; after release with noisy=1, full 11-edge latency applies again.
- BUTTON_PRESS_COUNT_EN defined: 3 clean presses -> press_count=3; force 0xFFFF then one press -> 0x0000.
